// File: rtl/midi_voice_alloc_pkg.sv
// rtl/midi_voice_alloc_pkg.sv - shared constants, FSM states and helpers for the MIDI voice allocator
package midi_voice_alloc_pkg;

    localparam logic [3:0]  MIDI_NOTE_OFF = 4'h8;
    localparam logic [3:0]  MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0]  MIDI_CTRL     = 4'hB;
    localparam logic [3:0]  MIDI_PRG      = 4'hC;
    localparam logic [3:0]  MIDI_BEND     = 4'hE;

    localparam logic [6:0]  CC_SUSTAIN    = 7'd64;
    localparam logic [6:0]  CC_ALL_OFF    = 7'd123;
    localparam logic [13:0] BEND_CENTER   = 14'd8192;

    typedef enum logic [2:0] {
        S_IDLE,
        S_D1,
        S_SCAN,
        S_COMMIT,
        S_CTRL,
        S_BEND,
        S_PRG
    } fsm_state_t;

    function automatic logic status_handled(input logic [3:0] nibble);
        return nibble inside {MIDI_NOTE_OFF, MIDI_NOTE_ON, MIDI_CTRL, MIDI_PRG, MIDI_BEND};
    endfunction

endpackage

// File: rtl/midi_voice_alloc_if.sv
// rtl/midi_voice_alloc_if.sv - muxed MIDI byte stream bundle
// Ports: byteready (1-cycle data strobe), cur_status (running status),
//        midibyte_nr (data byte index, odd = 1st), midi_in_data (data byte).
interface midi_voice_alloc_if;
    logic       byteready;
    logic [7:0] cur_status;
    logic [7:0] midibyte_nr;
    logic [7:0] midi_in_data;

    modport master (output byteready, cur_status, midibyte_nr, midi_in_data);
    modport slave  (input  byteready, cur_status, midibyte_nr, midi_in_data);
endinterface

// File: rtl/midi_voice_alloc_voice_slot.sv
// rtl/midi_voice_alloc_voice_slot.sv - per-voice key/channel/held/age registers and gate
// Ports: CLOCK_50, reset_reg_N; commands trig/age_inc/hold/rel with key_in/ch_in;
//        state outputs gate, held, key, ch, age.
module voice_slot #(
    parameter int AGE_W = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset_reg_N,
    input  logic             trig,
    input  logic             age_inc,
    input  logic             hold,
    input  logic             rel,
    input  logic [6:0]       key_in,
    input  logic [3:0]       ch_in,
    output logic             gate,
    output logic             held,
    output logic [6:0]       key,
    output logic [3:0]       ch,
    output logic [AGE_W-1:0] age
);

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            gate <= 1'b0;
            held <= 1'b0;
            key  <= '0;
            ch   <= '0;
            age  <= '0;
        end else if (trig) begin
            gate <= 1'b1;
            held <= 1'b0;
            key  <= key_in;
            ch   <= ch_in;
            age  <= '0;
        end else begin
            if (hold) begin
                held <= 1'b1;
            end else if (rel) begin
                gate <= 1'b0;
                held <= 1'b0;
            end
            // Saturate so long-held voices keep a stable "oldest" ranking.
            if (age_inc && age != {AGE_W{1'b1}}) begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// rtl/midi_voice_alloc.sv - MIDI note/controller decoder with voice allocation and stealing
// Ports: CLOCK_50, reset_reg_N (async, active-low); midi (byte stream, slave);
//        ch_enable (channel mask); voice_free (envelope done per voice);
//        keys_on, note_on, cur_key_adr/val, cur_vel, cur_key_ch, steal (note events);
//        sustain, pitch_cmd/pitch_val, prg_ch_cmd/prg_ch_data (controllers);
//        active_keys, busy, overrun (status).
module midi_voice_alloc
    import midi_voice_alloc_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3,
    parameter int AGE_W   = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset_reg_N,
    midi_voice_alloc_if.slave   midi,
    input  logic [15:0]         ch_enable,
    input  logic [VOICES-1:0]   voice_free,
    output logic [VOICES-1:0]   keys_on,
    output logic                note_on,
    output logic [V_WIDTH-1:0]  cur_key_adr,
    output logic [7:0]          cur_key_val,
    output logic [7:0]          cur_vel,
    output logic [3:0]          cur_key_ch,
    output logic                steal,
    output logic                sustain,
    output logic                pitch_cmd,
    output logic signed [13:0]  pitch_val,
    output logic                prg_ch_cmd,
    output logic [6:0]          prg_ch_data,
    output logic [V_WIDTH:0]    active_keys,
    output logic                busy,
    output logic                overrun
);

    fsm_state_t state, state_nx;

    logic [3:0]         ev_type, ev_ch, in_type;
    logic [6:0]         d1, d2;
    logic [V_WIDTH-1:0] scan_idx, m_idx, f_idx, u_idx, o_idx, target;
    logic               m_found, f_found, u_found;
    logic [AGE_W-1:0]   u_age, o_age;
    logic               accept, in_data, first_byte, second_byte, is_on, is_off;
    logic [V_WIDTH:0]   keys_cnt;

    logic [VOICES-1:0]  v_held, v_trig, v_inc, v_hold, v_rel;
    logic [6:0]         v_key [VOICES];
    logic [3:0]         v_ch  [VOICES];
    logic [AGE_W-1:0]   v_age [VOICES];

    assign in_type     = midi.cur_status[7:4];
    assign busy        = !(state == S_IDLE || state == S_D1);
    assign accept      = midi.byteready && !busy && ch_enable[midi.cur_status[3:0]]
                         && status_handled(in_type);
    // Index 0 would be the status byte itself, never a data byte.
    assign in_data     = midi.midibyte_nr != 8'd0;
    assign first_byte  = in_data && midi.midibyte_nr[0];
    assign second_byte = in_data && !midi.midibyte_nr[0];
    assign is_on       = ev_type == MIDI_NOTE_ON && d2 != 7'd0;
    assign is_off      = ev_type == MIDI_NOTE_OFF || (ev_type == MIDI_NOTE_ON && d2 == 7'd0);

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) state <= S_IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept && first_byte) state_nx = (in_type == MIDI_PRG) ? S_PRG : S_D1;
            S_D1: begin
                if (in_type != ev_type) begin
                    state_nx = S_IDLE;
                end else if (midi.byteready) begin
                    if (!accept || midi.midi_in_data[7] || !in_data) begin
                        state_nx = S_IDLE;
                    end else if (second_byte) begin
                        case (ev_type)
                            MIDI_NOTE_OFF, MIDI_NOTE_ON: state_nx = S_SCAN;
                            MIDI_CTRL:                   state_nx = S_CTRL;
                            MIDI_BEND:                   state_nx = S_BEND;
                            default:                     state_nx = S_IDLE;
                        endcase
                    end
                end
            end
            S_SCAN:  if (scan_idx == V_WIDTH'(VOICES - 1)) state_nx = S_COMMIT;
            default: state_nx = S_IDLE;
        endcase
    end

    // Allocation priority: retrigger matching key, then a finished voice,
    // then the oldest released one, and only then steal the oldest gated.
    always_comb begin
        target = o_idx;
        if (m_found)      target = m_idx;
        else if (f_found) target = f_idx;
        else if (u_found) target = u_idx;
    end

    always_comb begin
        v_trig = '0;
        v_inc  = '0;
        v_hold = '0;
        v_rel  = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (state == S_COMMIT && is_on) begin
                if (target == V_WIDTH'(i)) v_trig[i] = 1'b1;
                else                       v_inc[i]  = 1'b1;
            end
            if (state == S_COMMIT && is_off && m_found && m_idx == V_WIDTH'(i)) begin
                if (sustain) v_hold[i] = 1'b1;
                else         v_rel[i]  = 1'b1;
            end
            if (state == S_CTRL && d1 == CC_SUSTAIN && !d2[6] && v_held[i]) v_rel[i] = 1'b1;
            if (state == S_CTRL && d1 == CC_ALL_OFF && v_ch[i] == ev_ch)     v_rel[i] = 1'b1;
        end
    end

    always_comb begin
        keys_cnt = '0;
        for (int i = 0; i < VOICES; i++) keys_cnt = keys_cnt + (V_WIDTH+1)'(keys_on[i]);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            ev_type <= '0; ev_ch <= '0; d1 <= '0; d2 <= '0;
            scan_idx <= '0; m_idx <= '0; f_idx <= '0; u_idx <= '0; o_idx <= '0;
            m_found <= 1'b0; f_found <= 1'b0; u_found <= 1'b0; u_age <= '0; o_age <= '0;
            note_on <= 1'b0; cur_key_adr <= '0; cur_key_val <= '0; cur_vel <= '0;
            cur_key_ch <= '0; steal <= 1'b0; sustain <= 1'b0; pitch_cmd <= 1'b0;
            pitch_val <= '0; prg_ch_cmd <= 1'b0; prg_ch_data <= '0; active_keys <= '0;
            overrun <= 1'b0;
        end else begin
            note_on     <= 1'b0;
            steal       <= 1'b0;
            pitch_cmd   <= 1'b0;
            prg_ch_cmd  <= 1'b0;
            active_keys <= keys_cnt;
            if (midi.byteready && busy) overrun <= 1'b1;
            case (state)
                S_IDLE: if (accept && first_byte) begin
                    ev_type <= in_type;
                    ev_ch   <= midi.cur_status[3:0];
                    d1      <= midi.midi_in_data[6:0];
                    if (in_type == MIDI_PRG) prg_ch_data <= midi.midi_in_data[6:0];
                end
                S_D1: if (accept && in_type == ev_type && !midi.midi_in_data[7]) begin
                    if (first_byte) begin
                        ev_ch <= midi.cur_status[3:0];
                        d1    <= midi.midi_in_data[6:0];
                    end else if (second_byte) begin
                        d2       <= midi.midi_in_data[6:0];
                        scan_idx <= '0;
                        m_found  <= 1'b0;
                        f_found  <= 1'b0;
                        u_found  <= 1'b0;
                        if (ev_type == MIDI_BEND)
                            pitch_val <= $signed({midi.midi_in_data[6:0], d1} - BEND_CENTER);
                    end
                end
                S_SCAN: begin
                    if (!m_found && (keys_on[scan_idx] || v_held[scan_idx])
                        && v_key[scan_idx] == d1 && v_ch[scan_idx] == ev_ch) begin
                        m_found <= 1'b1;
                        m_idx   <= scan_idx;
                    end
                    if (!f_found && !keys_on[scan_idx] && voice_free[scan_idx]) begin
                        f_found <= 1'b1;
                        f_idx   <= scan_idx;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (!keys_on[scan_idx] && (!u_found || v_age[scan_idx] > u_age)) begin
                        u_found <= 1'b1;
                        u_idx   <= scan_idx;
                        u_age   <= v_age[scan_idx];
                    end
                    if (scan_idx == '0 || v_age[scan_idx] > o_age) begin
                        o_idx <= scan_idx;
                        o_age <= v_age[scan_idx];
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                S_COMMIT: if (is_on || m_found) begin
                    note_on     <= 1'b1;
                    cur_key_adr <= is_on ? target : m_idx;
                    cur_key_val <= {1'b0, d1};
                    cur_vel     <= {1'b0, d2};
                    cur_key_ch  <= ev_ch;
                    steal       <= is_on && !m_found && !f_found && !u_found;
                end
                S_CTRL:  if (d1 == CC_SUSTAIN) sustain <= d2[6];
                S_BEND:  pitch_cmd  <= 1'b1;
                S_PRG:   prg_ch_cmd <= 1'b1;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_slot
        voice_slot #(.AGE_W(AGE_W)) u_slot (
            .CLOCK_50    (CLOCK_50),
            .reset_reg_N (reset_reg_N),
            .trig        (v_trig[g]),
            .age_inc     (v_inc[g]),
            .hold        (v_hold[g]),
            .rel         (v_rel[g]),
            .key_in      (d1),
            .ch_in       (ev_ch),
            .gate        (keys_on[g]),
            .held        (v_held[g]),
            .key         (v_key[g]),
            .ch          (v_ch[g]),
            .age         (v_age[g])
        );
    end

endmodule
